score_latch_hs: RTL and testbench

SCORE_LATCH_HS -- requirements
Module: score_latch_hs

---
 rtl/score_latch_hs_if.sv | 37 +++
 rtl/score_latch_hs.sv | 152 +++++++++++++++
 tb/tb_score_latch_hs.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_latch_hs_if.sv
// Score latch / high-score table bus.
// Groups the mode, live score and readback index (driven by the master)
// with the displayed score, table readback and status flags (driven by the
// score_latch_hs block, which uses the slave modport).
//   select     : 00 PLAY, 01 GAME_OVER, 10 HOLD, 11 CLEAR
//   binary_in  : live score
//   table_idx  : table entry selected for readback
//   latch_out  : registered displayed score
//   high_score : table entry 0
//   table_out  : table[table_idx], 0 when the index is past the table
//   busy       : insertion scan in progress
//   new_record : one-cycle pulse when entry 0 is written
interface score_latch_hs_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [1:0]       select;
  logic [WIDTH-1:0] binary_in;
  logic [IDX_W-1:0] table_idx;
  logic [WIDTH-1:0] latch_out;
  logic [WIDTH-1:0] high_score;
  logic [WIDTH-1:0] table_out;
  logic             busy;
  logic             new_record;

  modport master (
    output select, binary_in, table_idx,
    input  latch_out, high_score, table_out, busy, new_record
  );

  modport slave (
    input  select, binary_in, table_idx,
    output latch_out, high_score, table_out, busy, new_record
  );
endinterface

// File: rtl/score_latch_hs.sv
// Score display latch with a sorted (descending) high-score table.
// A GAME_OVER entry captures the live score and an FSM scans the table one
// entry per cycle, then shifts the lower entries down and inserts the score.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : score_latch_hs_if slave modport (mode, score, readback, status)
module score_latch_hs #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  score_latch_hs_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned RD_N  = 1 << IDX_W;

  localparam logic [1:0] SEL_PLAY  = 2'b00;
  localparam logic [1:0] SEL_OVER  = 2'b01;
  localparam logic [1:0] SEL_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       prev_sel_q;
  logic [WIDTH-1:0] latch_q, latch_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] tbl_q [DEPTH];
  logic [WIDTH-1:0] tbl_d [DEPTH];
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] p_q, p_d;
  logic             busy_q, busy_d;
  logic             nrec_q, nrec_d;
  logic             over_entry;

  // A GAME_OVER entry is a rising edge of select==01, including 11->01 / 10->01.
  assign over_entry = (bus.select == SEL_OVER) && (prev_sel_q != SEL_OVER);

  // Next-state: display latch, insertion FSM, table update, CLEAR override.
  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    cap_d   = cap_q;
    tbl_d   = tbl_q;
    k_d     = k_q;
    p_d     = p_q;
    nrec_d  = 1'b0;

    if (bus.select == SEL_PLAY) begin
      latch_d = bus.binary_in;
    end else if (over_entry) begin
      latch_d = bus.binary_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (over_entry) begin
          cap_d   = bus.binary_in;
          k_d     = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Strict compare so ties never displace an existing entry.
        if (cap_q > tbl_q[k_q]) begin
          p_d     = k_q;
          state_d = ST_WRITE;
        end else if (k_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      ST_WRITE: begin
        // Shift entries below p down by one; the old last entry falls off.
        for (int i = 1; i < DEPTH; i++) begin
          if (IDX_W'(i) > p_q) begin
            tbl_d[i] = tbl_q[i-1];
          end
        end
        tbl_d[p_q] = cap_q;
        nrec_d     = (p_q == '0);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // CLEAR wipes the table and aborts any insertion; latch stays frozen.
    if (bus.select == SEL_CLEAR) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_d[i] = '0;
      end
      state_d = ST_IDLE;
      nrec_d  = 1'b0;
    end

    // busy covers the scan phase; the write cycle is reported by the table itself.
    busy_d = (state_d == ST_SCAN);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_sel_q <= '0;
      latch_q    <= '0;
      cap_q      <= '0;
      k_q        <= '0;
      p_q        <= '0;
      busy_q     <= 1'b0;
      nrec_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      prev_sel_q <= bus.select;
      latch_q    <= latch_d;
      cap_q      <= cap_d;
      k_q        <= k_d;
      p_q        <= p_d;
      busy_q     <= busy_d;
      nrec_q     <= nrec_d;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  // Readback array padded to the full index range; slots past the table read 0.
  logic [WIDTH-1:0] rd_arr [RD_N];
  for (genvar g = 0; g < RD_N; g++) begin : g_rd
    if (g < DEPTH) begin : g_ent
      assign rd_arr[g] = tbl_q[g];
    end else begin : g_pad
      assign rd_arr[g] = '0;
    end
  end

  assign bus.table_out  = rd_arr[bus.table_idx];
  assign bus.latch_out  = latch_q;
  assign bus.high_score = tbl_q[0];
  assign bus.busy       = busy_q;
  assign bus.new_record = nrec_q;

endmodule

// File: tb/tb_score_latch_hs.sv
// Directed bench for score_latch_hs (WIDTH=32, DEPTH=4).
module tb_score_latch_hs;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  score_latch_hs_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  score_latch_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] bin;
    logic [31:0] exp_latch;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_table(input string name, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++) begin
      bus.table_idx = 2'(i);
      #1;
      chk($sformatf("%s table_out[%0d]", name, i), bus.table_out, e[i]);
    end
    chk($sformatf("%s high_score", name), bus.high_score, e0);
  endtask

  // GAME_OVER entry with value v, then watch busy/new_record for 8 cycles.
  task automatic go(input logic [31:0] v, output int bcnt, output int ncnt);
    @(negedge clk);
    bus.select    = 2'b01;
    bus.binary_in = v;
    @(posedge clk);
    #1;
    bus.binary_in = v + 32'd1;
    bcnt = 0;
    ncnt = 0;
    for (int i = 0; i < 8; i++) begin
      bcnt += int'(bus.busy);
      ncnt += int'(bus.new_record);
      @(posedge clk);
      #1;
    end
    chk("go latch frozen", bus.latch_out, v);
    @(negedge clk);
    bus.select = 2'b10;
    @(posedge clk);
    #1;
  endtask

  // Clear then fill the table with {90,70,50,30}.
  task automatic build();
    int b, n;
    @(negedge clk);
    bus.select = 2'b11;
    @(posedge clk);
    #1;
    go(32'd30, b, n);
    go(32'd50, b, n);
    go(32'd70, b, n);
    go(32'd90, b, n);
  endtask

  initial begin
    int bc, nc;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{2'b00, 32'd55,         32'd55};
    vecs[1] = '{2'b00, 32'd7,          32'd7};
    vecs[2] = '{2'b10, 32'd9,          32'd7};
    vecs[3] = '{2'b10, 32'd0,          32'd7};
    vecs[4] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vecs[5] = '{2'b11, 32'd5,          32'hFFFF_FFFF};
    vecs[6] = '{2'b11, 32'd1,          32'hFFFF_FFFF};
    vecs[7] = '{2'b00, 32'd0,          32'd0};
    vecs[8] = '{2'b00, 32'd55,         32'd55};

    // Reset state.
    reset         = 1'b1;
    bus.select    = 2'b00;
    bus.binary_in = 32'd123;
    bus.table_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset latch", bus.latch_out, 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset new_record", 32'(bus.new_record), 32'd0);
    check_table("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // PLAY / HOLD / CLEAR latch behaviour.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.select    = vecs[i].sel;
      bus.binary_in = vecs[i].bin;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d latch", i), bus.latch_out, vecs[i].exp_latch);
      chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'd0);
      chk($sformatf("vec%0d new_record", i), 32'(bus.new_record), 32'd0);
    end

    // First game over into an empty table.
    go(32'd55, bc, nc);
    chk("go55 busy cycles", 32'(bc), 32'd1);
    chk("go55 new_record pulses", 32'(nc), 32'd1);
    check_table("go55", 55, 0, 0, 0);

    build();
    check_table("build", 90, 70, 50, 30);

    // Mid-table insert.
    go(32'd60, bc, nc);
    chk("go60 busy cycles", 32'(bc), 32'd3);
    chk("go60 new_record pulses", 32'(nc), 32'd0);
    check_table("go60", 90, 70, 60, 50);

    // Tie with the lowest entry: no insert, full scan.
    build();
    go(32'd30, bc, nc);
    chk("go30 busy cycles", 32'(bc), 32'd4);
    chk("go30 new_record pulses", 32'(nc), 32'd0);
    check_table("go30", 90, 70, 50, 30);

    // New record.
    go(32'd95, bc, nc);
    chk("go95 busy cycles", 32'(bc), 32'd1);
    chk("go95 new_record pulses", 32'(nc), 32'd1);
    check_table("go95", 95, 90, 70, 50);

    // Tie mid-table lands below the existing equal entry.
    build();
    go(32'd70, bc, nc);
    chk("go70 busy cycles", 32'(bc), 32'd3);
    chk("go70 new_record pulses", 32'(nc), 32'd0);
    check_table("go70", 90, 70, 70, 50);

    // CLEAR one cycle after capture aborts the insertion.
    @(negedge clk);
    bus.select    = 2'b01;
    bus.binary_in = 32'd40;
    @(posedge clk);
    @(negedge clk);
    bus.select = 2'b11;
    @(posedge clk);
    #1;
    chk("clear busy", 32'(bus.busy), 32'd0);
    chk("clear latch frozen", bus.latch_out, 32'd40);
    check_table("clear", 0, 0, 0, 0);
    @(negedge clk);
    bus.select = 2'b10;
    bc = 0;
    nc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      bc += int'(bus.busy);
      nc += int'(bus.new_record);
    end
    chk("clear later busy", 32'(bc), 32'd0);
    chk("clear new_record pulses", 32'(nc), 32'd0);
    check_table("after clear", 0, 0, 0, 0);

    // 01 -> 10 -> 01 while busy: latch follows, single insertion.
    build();
    @(negedge clk);
    bus.select    = 2'b01;
    bus.binary_in = 32'd60;
    @(posedge clk);
    #1;
    chk("reentry latch0", bus.latch_out, 32'd60);
    @(negedge clk);
    bus.select    = 2'b10;
    bus.binary_in = 32'd61;
    @(posedge clk);
    #1;
    chk("reentry hold latch", bus.latch_out, 32'd60);
    @(negedge clk);
    bus.select    = 2'b01;
    bus.binary_in = 32'd99;
    @(posedge clk);
    #1;
    chk("reentry latch", bus.latch_out, 32'd99);
    bus.binary_in = 32'd5;
    nc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      nc += int'(bus.new_record);
    end
    chk("reentry new_record pulses", 32'(nc), 32'd0);
    chk("reentry latch frozen", bus.latch_out, 32'd99);
    @(negedge clk);
    bus.select = 2'b10;
    @(posedge clk);
    #1;
    check_table("reentry", 90, 70, 60, 50);

    // Reset during SCAN, then GAME_OVER held through release.
    @(negedge clk);
    bus.select    = 2'b01;
    bus.binary_in = 32'd10;
    @(posedge clk);
    @(negedge clk);
    reset         = 1'b1;
    bus.binary_in = 32'd77;
    @(posedge clk);
    #1;
    chk("scan reset latch", bus.latch_out, 32'd0);
    chk("scan reset busy", 32'(bus.busy), 32'd0);
    chk("scan reset new_record", 32'(bus.new_record), 32'd0);
    check_table("scan reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("release latch", bus.latch_out, 32'd77);
    chk("release busy", 32'(bus.busy), 32'd1);
    nc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      nc += int'(bus.new_record);
    end
    chk("release new_record pulses", 32'(nc), 32'd1);
    @(negedge clk);
    bus.select = 2'b10;
    @(posedge clk);
    #1;
    check_table("release", 77, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
